secded_rx_assembler: RTL

- Receive-side sequencer for the SEC-DED UART link. Accepts Hamming(8,4) codewords from the UART RX byte stream and pairs them low nibble first, then high nibble.
- Each codeword is decoded through one internal instance of the team's combinational Hamming(8,4) decoder. Codeword format is {p3,d3,d2,d1,p2,d0,p1,p0}.
- Emits one data byte per codeword pair on a valid/ready interface, with per-byte correction and uncorrectable-error flags.
- Sits between the UART RX core and the consumer of received bytes.

---
 rtl/secded_rx_assembler_if.sv | 23 ++
 rtl/secded_rx_assembler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/secded_rx_assembler_if.sv
// Codeword-in / byte-out handshake bundle for the SEC-DED receive assembler.
// slave  : the assembler itself.
// master : the environment (UART RX core on the codeword side, consumer on the byte side).
interface secded_rx_assembler_if;
  logic       code_valid;
  logic [7:0] code_in;
  logic       code_ready;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_corrected;
  logic       byte_dbl_err;

  modport slave (
    input  code_valid, code_in, byte_ready,
    output code_ready, byte_valid, byte_data, byte_corrected, byte_dbl_err
  );

  modport master (
    output code_valid, code_in, byte_ready,
    input  code_ready, byte_valid, byte_data, byte_corrected, byte_dbl_err
  );
endinterface

// File: rtl/secded_rx_assembler.sv
// SEC-DED receive assembler: pairs two Hamming(8,4) codewords (low nibble
// first) into one byte with correction / double-error flags.
// Codeword bits 6..0 are Hamming positions 7..1 ({d3,d2,d1,p2,d0,p1,p0}),
// bit 7 (p3) is the overall parity bit.
// Optional error counters are enabled by defining SECDED_ERR_CNT_EN.

// Combinational Hamming(8,4) SEC-DED decoder.
module hamming84_decode (
  input  logic [7:0] code,
  output logic [3:0] data,
  output logic       corrected,
  output logic       dbl_err
);
  logic [2:0] syn;
  logic       par_odd;
  logic [7:0] fixed;

  // Syndrome points at the flipped Hamming position; overall parity tells single from double.
  always_comb begin
    // NOTE: every output of a combinational block is assigned first so no path infers a latch.
    fixed     = code;
    syn[0]    = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1]    = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2]    = code[3] ^ code[4] ^ code[5] ^ code[6];
    par_odd   = ^code;
    if (par_odd && (syn != 3'd0)) begin
      fixed[syn - 3'd1] = ~code[syn - 3'd1];
    end
    // Odd parity with zero syndrome is an error in p3 itself: still a correction.
    corrected = par_odd;
    dbl_err   = !par_odd && (syn != 3'd0);
    data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end
endmodule

module secded_rx_assembler #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  secded_rx_assembler_if.slave  bus,
  output logic                  timeout_err,
  output logic                  busy
`ifdef SECDED_ERR_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      dbl_cnt,
  output logic [CNT_W-1:0]      to_cnt
`endif
);
  localparam int            TW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    lo_reg;
  logic          lo_corr;
  logic          lo_dbl;

  logic [3:0]    dec_data;
  logic          dec_corr;
  logic          dec_dbl;
  logic          accept;
  logic          expire;

  // Both nibbles arrive on code_in at different times, so one decoder serves both.
  hamming84_decode u_dec (
    .code      (bus.code_in),
    .data      (dec_data),
    .corrected (dec_corr),
    .dbl_err   (dec_dbl)
  );

  // Ready depends on state only; no bypass from the byte handshake.
  assign bus.code_ready = (state != S_OUT);
  assign accept         = bus.code_valid && bus.code_ready;
  assign expire         = (state == S_HI) && !accept && (timer == TMAX);

  // Assembly FSM with registered byte outputs, timeout and busy.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state              <= S_LO;
      timer              <= '0;
      lo_reg             <= 4'h0;
      lo_corr            <= 1'b0;
      lo_dbl             <= 1'b0;
      bus.byte_valid     <= 1'b0;
      bus.byte_data      <= 8'h00;
      bus.byte_corrected <= 1'b0;
      bus.byte_dbl_err   <= 1'b0;
      timeout_err        <= 1'b0;
      busy               <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_LO: begin
          if (accept) begin
            lo_reg  <= dec_data;
            lo_corr <= dec_corr;
            lo_dbl  <= dec_dbl;
            timer   <= '0;
            busy    <= 1'b1;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (accept) begin
            bus.byte_data      <= {dec_data, lo_reg};
            bus.byte_corrected <= lo_corr | dec_corr;
            bus.byte_dbl_err   <= lo_dbl | dec_dbl;
            bus.byte_valid     <= 1'b1;
            state              <= S_OUT;
          end else if (expire) begin
            timeout_err <= 1'b1;
            lo_reg      <= 4'h0;
            lo_corr     <= 1'b0;
            lo_dbl      <= 1'b0;
            timer       <= '0;
            busy        <= 1'b0;
            state       <= S_LO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.byte_valid && bus.byte_ready) begin
            bus.byte_valid     <= 1'b0;
            bus.byte_corrected <= 1'b0;
            bus.byte_dbl_err   <= 1'b0;
            busy               <= 1'b0;
            state              <= S_LO;
          end
        end
        default: state <= S_LO;
      endcase
    end
  end

`ifdef SECDED_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating event counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      if (accept && dec_corr && (corr_cnt != CNT_MAX)) corr_cnt <= corr_cnt + 1'b1;
      if (accept && dec_dbl  && (dbl_cnt  != CNT_MAX)) dbl_cnt  <= dbl_cnt  + 1'b1;
      if (expire             && (to_cnt   != CNT_MAX)) to_cnt   <= to_cnt   + 1'b1;
    end
  end
`endif
endmodule
